// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } disp_state_t;

  // All segments off, decimal point off (active-low bus).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-high {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/disp_scan_ctrl_hex2seg.sv
// Nibble to active-high seven-segment glyph lookup.
// Latency: combinational.
// Backpressure: none.
module hex2seg
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = GLYPH[nib];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller with per-slot blanking and frame-aligned value updates.
// Latency: load -> pending next edge; new glyph at first SHOW of digit 0 after the frame boundary.
// Backpressure: none; a later load overwrites the pending word. Optional PWM dimming under DISP_DIM_EN.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
`ifdef DISP_DIM_EN
  input  logic [1:0]  dim,
`endif
  output logic [1:0]  digit,
  output logic [7:0]  leds,
  output logic        pending,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  if (!(BLANK_CYCLES > 0 && BLANK_CYCLES < DIV)) begin : g_bad_blank
    $error("disp_scan_ctrl: BLANK_CYCLES must satisfy 0 < BLANK_CYCLES < CLK_HZ/SCAN_HZ");
  end

  disp_state_t   state;
  logic [CW-1:0] slot_cnt;
  logic [15:0]   val_sh, val_pd;
  logic [3:0]    dp_sh, dp_pd;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic [7:0]    glyph_n;
  logic          lit_next;

  assign nib     = val_sh[{digit, 2'b00} +: 4];
  assign glyph_n = ~{dp_sh[digit], seg};

  hex2seg u_hex2seg (
    .nib (nib),
    .seg (seg)
  );

`ifdef DISP_DIM_EN
  localparam int S = DIV - BLANK_CYCLES;

  logic [1:0] dim_q;
  logic [1:0] dim_eff;
  int         limit;

  // Latch the dim level once per slot so the lit window cannot change mid-slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dim_q <= 2'd0;
    else if (slot_cnt == '0)
      dim_q <= dim;
  end

  // Decide whether the cycle after this edge falls inside the lit part of SHOW.
  always_comb begin
    dim_eff = (slot_cnt == '0) ? dim : dim_q;
    case (dim_eff)
      2'd0:    limit = S;
      2'd1:    limit = (3 * S) / 4;
      2'd2:    limit = S / 2;
      default: limit = S / 4;
    endcase
    lit_next = (int'(slot_cnt) + 1 - BLANK_CYCLES) < limit;
  end
`else
  assign lit_next = 1'b1;
`endif

  // Slot sequencer, frame-boundary word swap and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK;
      slot_cnt   <= '0;
      digit      <= 2'd0;
      leds       <= SEG_BLANK;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      val_sh     <= 16'h0;
      dp_sh      <= 4'h0;
      val_pd     <= 16'h0;
      dp_pd      <= 4'h0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        val_pd  <= value;
        dp_pd   <= dp;
        pending <= 1'b1;
      end
      case (state)
        BLANK: begin
          slot_cnt <= slot_cnt + 1'b1;
          if (slot_cnt == BLANK_LAST) begin
            state <= SHOW;
            leds  <= lit_next ? glyph_n : SEG_BLANK;
          end
        end
        SHOW: begin
          if (slot_cnt == SLOT_LAST) begin
            // Blank on the same edge the digit steps to avoid ghosting.
            slot_cnt <= '0;
            state    <= BLANK;
            leds     <= SEG_BLANK;
            digit    <= digit + 1'b1;
            if (digit == 2'd3) begin
              frame_done <= 1'b1;
              if (load) begin
                // A load on the boundary goes straight to the shadow word.
                val_sh  <= value;
                dp_sh   <= dp;
                pending <= 1'b0;
              end else if (pending) begin
                val_sh  <= val_pd;
                dp_sh   <= dp_pd;
                pending <= 1'b0;
              end
            end
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
            leds     <= lit_next ? glyph_n : SEG_BLANK;
          end
        end
        default: begin
          state    <= BLANK;
          slot_cnt <= '0;
          leds     <= SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl with an arithmetic timeline model.
// Latency: expected outputs are queued at each clock edge and compared at the following falling edge.
// Backpressure: none.
module tb_disp_scan_ctrl;

  localparam int DIV   = 10;
  localparam int BLK   = 2;
  localparam int S     = DIV - BLK;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        load = 1'b0;
`ifdef DISP_DIM_EN
  logic [1:0]  dim = 2'd2;
`endif
  logic [1:0]  digit;
  logic [7:0]  leds;
  logic        pending;
  logic        frame_done;

  always #5 clk = ~clk;

  disp_scan_ctrl #(
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp         (dp),
    .load       (load),
`ifdef DISP_DIM_EN
    .dim        (dim),
`endif
    .digit      (digit),
    .leds       (leds),
    .pending    (pending),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [1:0] digit;
    logic [7:0] leds;
    logic       pending;
    logic       frame_done;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Independent active-high {g..a} reference glyphs.
  logic [6:0] ref_glyph [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Model: time since reset release plus load history.
  int          e;
  bit          have_load;
  int          last_e;
  logic [15:0] last_val, shown_val;
  logic [3:0]  last_dp, shown_dp;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    e = 0;
    have_load = 0;
    last_e = 0;
    last_val = 16'h0;
    last_dp = 4'h0;
    shown_val = 16'h0;
    shown_dp = 4'h0;
  endtask

  function automatic bit lit(input int show_pos);
`ifdef DISP_DIM_EN
    return show_pos < (S * (4 - int'(dim))) / 4;
`else
    return show_pos < S;
`endif
  endfunction

  // Apply one cycle of inputs, then queue what the display must show after that edge.
  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d);
    exp_t x;
    int pos, dig, bnd;
    load = ld;
    value = v;
    dp = d;
    @(posedge clk);
    e++;
    if (ld) begin
      have_load = 1;
      last_e = e;
      last_val = v;
      last_dp = d;
    end
    if (e % FRAME == 0 && have_load) begin
      shown_val = last_val;
      shown_dp = last_dp;
    end
    bnd = e - (e % FRAME);
    pos = e % DIV;
    dig = (e / DIV) % 4;
    x.digit = 2'(dig);
    x.pending = have_load && (last_e > bnd);
    x.frame_done = (e % FRAME == 0);
    if (pos < BLK || !lit(pos - BLK))
      x.leds = 8'hFF;
    else
      x.leds = ~{shown_dp[dig], ref_glyph[shown_val[dig*4 +: 4]]};
    sb.push_back(x);
    #1;
  endtask

  task automatic step_rand(input int one_in);
    step($urandom_range(0, one_in - 1) == 0, 16'($urandom), 4'($urandom));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_digit"}, 16'(digit), 16'h0);
    chk({tag, "_leds"}, 16'(leds), 16'h00FF);
    chk({tag, "_pending"}, 16'(pending), 16'h0);
    chk({tag, "_frame_done"}, 16'(frame_done), 16'h0);
  endtask

  // Monitor: compare every queued expectation once its edge has happened.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("digit", 16'(digit), 16'(x.digit));
        chk("leds", 16'(leds), 16'(x.leds));
        chk("pending", 16'(pending), 16'(x.pending));
        chk("frame_done", 16'(frame_done), 16'(x.frame_done));
      end
    end
  end

  initial begin
    model_reset();
    #12;
    chk_reset_state("in_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state("post_release");

    // Directed frames: mid-frame load, double load, boundary load.
    while (e < 4 * FRAME) begin
      case (e + 1)
        15:      step(1'b1, 16'h1234, 4'b0001);
        45:      step(1'b1, 16'hAAAA, 4'b0000);
        60:      step(1'b1, 16'h5555, 4'b0000);
        120:     step(1'b1, 16'hBEEF, 4'b1010);
        default: step(1'b0, 16'($urandom), 4'($urandom));
      endcase
    end

    // Random load traffic.
    repeat (600) step_rand(25);

    // Reset during SHOW of digit 2 while a word is pending.
    while (e % FRAME != 19) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'hC0DE, 4'b0100);
    while (e % FRAME != 25) step(1'b0, 16'h0, 4'h0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_state("async_reset");
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk_reset_state("rerelease");

    repeat (400) step_rand(20);

    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan controller for the shared four-digit seven-segment display. It time-multiplexes a 16-bit hex value across the four digits by stepping the 2-bit digit index that drives the digit-enable decoder. It drives the shared active-low segment bus with the glyph for the selected nibble. It inserts a blanking gap before each digit change to prevent ghosting, and applies new values only at frame boundaries so a displayed word never tears.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `SCAN_HZ`, 1000: digit slot rate; slot length `DIV = CLK_HZ/SCAN_HZ` cycles.
- `BLANK_CYCLES`, 64: blanked cycles at the start of every slot; elaboration error unless `0 < BLANK_CYCLES < DIV`.
- `clk  in  1`: system clock, rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `value  in  16`: hex word; `value[3:0]` is shown on digit 0.
- `dp  in  4`: decimal points, bit n lights digit n's dp.
- `load  in  1`: one-cycle strobe capturing `value`/`dp` into the pending register.
- `digit  out  2`: active digit index, feeds the digit-enable decoder.
- `leds  out  8`: segments `{dp,g..a}`, active-low; `8'hFF` means blank.
- `pending  out  1`: a loaded value is waiting for the next frame boundary.
- `frame_done  out  1`: one-cycle pulse on the digit 3→0 wrap.

## Operation
- States: `BLANK`, `SHOW`. `slot_cnt` has width `$clog2(DIV)`.
  - `BLANK`: `leds = 8'hFF` for `BLANK_CYCLES` cycles, then go to `SHOW`.
  - `SHOW`: `leds = ~{dp_sh[digit], seg(nibble)}` for `DIV-BLANK_CYCLES` cycles.
  - At the end of `SHOW`: `digit <= digit+1` (wraps 3→0), `slot_cnt <= 0`, state → `BLANK`.
- Shadow word `val_sh`/`dp_sh` feeds the glyph lookup. Pending word `val_pd`/`dp_pd` is loaded by `load`.
- `load` writes the pending word and sets `pending`. A second `load` before the boundary overwrites the pending word; last writer wins.
- Frame boundary is the edge where `digit` wraps 3→0. On that edge:
  - if `pending`, copy pending to shadow and clear `pending`;
  - `frame_done` = 1 for that cycle.
- `load` on the boundary cycle writes `value`/`dp` directly to the shadow, leaves `pending` cleared, and discards any older pending word.
- Nibble select is `val_sh[4*digit +: 4]`. The glyph map covers 0–F, standard hex forms.
- Reset values:
  - outputs: `digit=0`, `leds=8'hFF`, `pending=0`, `frame_done=0`;
  - internal: state `BLANK`, `slot_cnt=0`, shadow and pending words `0`.
- Reset asserted mid-slot returns to these values immediately. The first slot after release is a full `BLANK` on digit 0.

## Timing
- All outputs are registered.
- `digit` and `leds` change on the same edge. Entering `BLANK` blanks `leds` on the edge where `digit` steps, so an enabled digit never shows its neighbour's glyph.
- Slot length is exactly `DIV` cycles; frame length is `4*DIV` cycles.
- `load` → `pending` high on the next edge. The new glyph appears at the first `SHOW` of digit 0 after the boundary.

## Configuration
- `DISP_DIM_EN`: when defined, adds input `dim  in  2` and PWM-dims the `SHOW` window. Let `S = DIV-BLANK_CYCLES`; segments are driven only while the `SHOW` count is below:
  - `dim=0`: S
  - `dim=1`: 3S/4
  - `dim=2`: S/2
  - `dim=3`: S/4
- Outside that window `leds = 8'hFF`. `dim` is sampled at each slot start.
- When undefined: no `dim` port, and the full `SHOW` window is always lit.

## Structure
- Shared package `disp_pkg`:
  - `disp_state_t` enum `{BLANK, SHOW}`;
  - `SEG_BLANK = 8'hFF`;
  - the 16-entry glyph constant array.
- Sub-module `hex2seg`: combinational nibble → 7-bit active-high segment map, instantiated once on the selected nibble.

## Test plan
Bench uses `CLK_HZ=1000`, `SCAN_HZ=100` (`DIV=10`), `BLANK_CYCLES=2`.
- Reset release → `digit=0`, `leds=FF` for 2 cycles, then glyph `0` (`leds=8'hC0`) for 8 cycles, then `digit=1`.
- `load` with `value=16'h1234` mid-frame → `pending=1` until the boundary; `frame_done` pulses, `pending` clears; digits 0..3 then show 4, 3, 2, 1.
- Two loads (`16'hAAAA`, then `16'h5555`) in one frame → only `5555` is displayed next frame.
- `load` (`16'hBEEF`) on the boundary cycle → `BEEF` is displayed in that same frame and `pending` stays 0.
- `reset` asserted during `SHOW` of digit 2 → the same cycle shows `digit=0`, `leds=FF`, `pending=0`.
- With `DISP_DIM_EN`, `dim=2` → 2 blank, then 4 lit, then 4 blank cycles per slot; `dp=4'b0001` → dp lit on digit 0 only.
